// File: rtl/alu24_arbiter.sv
// Round-robin front end that shares one combinational ALU24 between two requesters.
// The issued op is held at the ALU for its settle window, then the result waits on a response channel until accepted.
module alu24_arbiter #(
    parameter int DW         = 24,
    parameter int MUL_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [2:0]    req0_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,

    output logic [2:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_z,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_y,
    output logic          rsp_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0]    OP_MUL   = 3'b001;
    localparam int            CW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic          rr;
    logic [CW-1:0] cnt;
    logic          grant0;
    logic          grant1;
    logic          grant_any;
    logic          exec_done;

    // MUL needs MUL_CYCLES edges in EXEC before the ALU output is trusted.
    function automatic logic op_done(input logic [2:0] op, input logic [CW-1:0] c);
        return (op != OP_MUL) || (c == CNT_LAST);
    endfunction

    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~rr);
        grant1 = req1_valid & (~req0_valid | rr);
    end

    assign grant_any  = grant0 | grant1;
    assign exec_done  = op_done(alu_op, cnt);
    // Gated by rst_n so no request is acknowledged while reset is asserted.
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    if (exec_done) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        rr  <= ~grant1;
                        cnt <= '0;
                    end
                end
                EXEC: begin
                    if (exec_done) rsp_valid <= 1'b1;
                    else           cnt       <= cnt + CW'(1);
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Operand and result registers: alu_* frozen from grant until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            rsp_id <= 1'b0;
            rsp_y  <= '0;
            rsp_z  <= 1'b0;
        end else begin
            if ((state == IDLE) && grant_any) begin
                alu_op <= grant1 ? req1_op : req0_op;
                alu_a  <= grant1 ? req1_a  : req0_a;
                alu_b  <= grant1 ? req1_b  : req0_b;
                rsp_id <= grant1;
            end
            if ((state == EXEC) && exec_done) begin
                rsp_y <= alu_y;
                rsp_z <= alu_z;
            end
        end
    end

endmodule

// File: tb/tb_alu24_arbiter.sv
// Bench for alu24_arbiter: behavioural ALU24, directed requests, scoreboard queue drained by a monitor.
module tb_alu24_arbiter;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]    req0_op, req1_op, alu_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_y;
    logic          alu_z;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_z;
    logic [DW-1:0] rsp_y;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] y;
        logic          z;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu24_arbiter #(.DW(DW), .MUL_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_z(rsp_z)
    );

    always #5 clk = ~clk;

    // ALU24 stand-in: 000 ADD, 001 MUL, 010 SUB, 011 OR, 100 AND, 101 LI (Y=B), others 0.
    always_comb begin
        case (alu_op)
            3'b000:  alu_y = alu_a + alu_b;
            3'b001:  alu_y = alu_a * alu_b;
            3'b010:  alu_y = alu_a - alu_b;
            3'b011:  alu_y = alu_a | alu_b;
            3'b100:  alu_y = alu_a & alu_b;
            3'b101:  alu_y = alu_b;
            default: alu_y = '0;
        endcase
        alu_z = (alu_y == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, want event", name);
    endtask

    // Monitor: pop and compare on every accepted response; also guard grant exclusivity.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req0_ready || req1_ready)
                    check("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
                if (rsp_valid && rsp_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got y=0x%0h id=%0d, want no response", rsp_y, rsp_id);
                    end else begin
                        e = q.pop_front();
                        check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                        check("rsp_y",  {8'd0, rsp_y},   {8'd0, e.y});
                        check("rsp_z",  {31'd0, rsp_z},  {31'd0, e.z});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input logic n, input logic v, input logic [2:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (n) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) begin who = 0; break; end
            if (req1_ready) begin who = 1; break; end
        end
        if (who < 0) fail("grant_timeout");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) fail("drain_timeout");
        @(posedge clk); #1;
    endtask

    // Single requester op; lat = edges from grant edge until rsp_valid is seen.
    task automatic issue(input logic n, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] ey, input logic ez,
                         output int lat);
        int who;
        lat = -1;
        set_req(n, 1'b1, op, a, b);
        wait_grant(who);
        if (who < 0) begin
            set_req(n, 1'b0, 3'b000, '0, '0);
            return;
        end
        check("grant_id", who, {31'd0, n});
        q.push_back(exp_t'{id: n, y: ey, z: ez});
        @(posedge clk); #1;
        set_req(n, 1'b0, 3'b000, '0, '0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            check("alu_op_stable", {29'd0, alu_op}, {29'd0, op});
            check("alu_a_stable",  {8'd0, alu_a},   {8'd0, a});
            check("alu_b_stable",  {8'd0, alu_b},   {8'd0, b});
            lat++;
        end
    endtask

    // Both requesters held valid; grants must alternate starting with 'first'.
    task automatic run_both(input int nops, input logic first,
                            input logic [2:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                            input logic [DW-1:0] y0, input logic z0,
                            input logic [2:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                            input logic [DW-1:0] y1, input logic z1);
        int who;
        set_req(1'b0, 1'b1, op0, a0, b0);
        set_req(1'b1, 1'b1, op1, a1, b1);
        for (int k = 0; k < nops; k++) begin
            wait_grant(who);
            if (who < 0) break;
            check("rr_order", who, {31'd0, first ^ (k % 2 == 1)});
            if (who == 1) q.push_back(exp_t'{id: 1'b1, y: y1, z: z1});
            else          q.push_back(exp_t'{id: 1'b0, y: y0, z: z0});
            @(posedge clk); #1;
        end
        set_req(1'b0, 1'b0, 3'b000, '0, '0);
        set_req(1'b1, 1'b0, 3'b000, '0, '0);
        wait_idle();
    endtask

    initial begin
        int lat;
        int who;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 3'b011, 24'h111111, 24'h222222);
        set_req(1'b1, 1'b1, 3'b000, 24'h333333, 24'h444444);
        repeat (3) @(negedge clk);
        check("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        check("rst_rsp_id",     {31'd0, rsp_id},     32'd0);
        check("rst_rsp_y",      {8'd0, rsp_y},       32'd0);
        check("rst_rsp_z",      {31'd0, rsp_z},      32'd0);
        check("rst_alu_op",     {29'd0, alu_op},     32'd0);
        check("rst_alu_a",      {8'd0, alu_a},       32'd0);
        check("rst_alu_b",      {8'd0, alu_b},       32'd0);
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 3'b000, '0, '0);
        set_req(1'b1, 1'b0, 3'b000, '0, '0);
        rsp_ready = 1'b1;
        rst_n     = 1'b1;

        // T2: both valid after reset, req0 wins first
        run_both(2, 1'b0, 3'b011, 24'h0F0000, 24'h0000FF, 24'h0F00FF, 1'b0,
                          3'b101, 24'h000000, 24'h123456, 24'h123456, 1'b0);

        // T3: six back-to-back contended ops alternate 0,1,0,1,0,1
        run_both(6, 1'b0, 3'b000, 24'h000010, 24'h000020, 24'h000030, 1'b0,
                          3'b010, 24'h000007, 24'h000007, 24'h000000, 1'b1);

        // T1: plain ADD, one cycle from grant to response
        issue(1'b0, 3'b000, 24'h000005, 24'h000003, 24'h000008, 1'b0, lat);
        check("t1_latency", lat, 32'd1);
        wait_idle();

        // T4: MUL on req1 takes two EXEC cycles, low 24 bits returned
        issue(1'b1, 3'b001, 24'hFFFFFF, 24'h000002, 24'hFFFFFE, 1'b0, lat);
        check("t4_latency", lat, 32'd2);
        wait_idle();

        // Undefined opcode passes through; ALU returns zero
        issue(1'b0, 3'b110, 24'h000005, 24'h000005, 24'h000000, 1'b1, lat);
        check("undef_latency", lat, 32'd1);
        wait_idle();

        // T5: wrap-to-zero ADD held under back-pressure with competing requests
        rsp_ready = 1'b0;
        issue(1'b0, 3'b000, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, lat);
        check("t5_latency", lat, 32'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 3'b000, 24'h000001, 24'h000001);
        set_req(1'b1, 1'b1, 3'b011, 24'h000002, 24'h000004);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", {31'd0, rsp_valid},  32'd1);
            check("t5_hold_y",     {8'd0, rsp_y},       32'd0);
            check("t5_hold_z",     {31'd0, rsp_z},      32'd1);
            check("t5_hold_id",    {31'd0, rsp_id},     32'd0);
            check("t5_req0_ready", {31'd0, req0_ready}, 32'd0);
            check("t5_req1_ready", {31'd0, req1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 3'b000, '0, '0);
        set_req(1'b1, 1'b0, 3'b000, '0, '0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_accepted", {31'd0, rsp_valid}, 32'd0);
        wait_idle();

        // T6: reset during MUL EXEC drops the op; req0 wins afterwards
        set_req(1'b1, 1'b1, 3'b001, 24'hFFFFFF, 24'h000003);
        wait_grant(who);
        check("t6_grant", who, 32'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 3'b000, 24'h000002, 24'h000002);
        rst_n = 1'b0;
        #1;
        check("t6_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        check("t6_rsp_y",      {8'd0, rsp_y},       32'd0);
        check("t6_alu_op",     {29'd0, alu_op},     32'd0);
        check("t6_alu_a",      {8'd0, alu_a},       32'd0);
        check("t6_alu_b",      {8'd0, alu_b},       32'd0);
        check("t6_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("t6_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_both(2, 1'b0, 3'b000, 24'h000002, 24'h000002, 24'h000004, 1'b0,
                          3'b001, 24'hFFFFFF, 24'h000003, 24'hFFFFFD, 1'b0);

        check("scoreboard_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
